// File: rtl/pingpong_ram2b.sv
// Two-bank ping-pong RAM with dual write and dual read ports.
// Writer fills one bank while reader drains the other; banks swap on done/done.
module pingpong_ram2b #(
   parameter int WORD_SIZE = 16,
   parameter int MEM_SIZE  = 32,
   parameter int ADDR_SIZE = $clog2(MEM_SIZE),
   parameter int CNT_SIZE  = 8
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_write_en_A,
   input  logic                 i_write_en_B,
   input  logic [ADDR_SIZE-1:0] i_write_addr_A,
   input  logic [ADDR_SIZE-1:0] i_write_addr_B,
   input  logic [WORD_SIZE-1:0] i_write_data_A,
   input  logic [WORD_SIZE-1:0] i_write_data_B,
   input  logic                 i_write_done,
   output logic                 o_write_ready,
   input  logic                 i_read_en_A,
   input  logic                 i_read_en_B,
   input  logic [ADDR_SIZE-1:0] i_read_addr_A,
   input  logic [ADDR_SIZE-1:0] i_read_addr_B,
   input  logic                 i_read_done,
   output logic                 o_read_ready,
   output logic [WORD_SIZE-1:0] o_read_data_A,
   output logic [WORD_SIZE-1:0] o_read_data_B,
   output logic                 o_read_valid_A,
   output logic                 o_read_valid_B,
   output logic                 o_swap,
   output logic                 o_collision,
   output logic [CNT_SIZE-1:0]  o_frame_count
);

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      FILL_BUSY = 2'd1,
      HOLD      = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   wr_bank;
   logic   swap;

   logic [WORD_SIZE-1:0] mem [2*MEM_SIZE];

   logic wr_ok_A, wr_ok_B, rd_ok_A, rd_ok_B;

   assign o_write_ready = (state != HOLD);
   assign o_read_ready  = (state != FILL);

   assign wr_ok_A = i_write_en_A & o_write_ready;
   assign wr_ok_B = i_write_en_B & o_write_ready;
   assign rd_ok_A = i_read_en_A & o_read_ready;
   assign rd_ok_B = i_read_en_B & o_read_ready;

   // Writer-done with an empty reader swaps at once, so no such state exists.
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      unique case (state)
         FILL: begin
            if (i_write_done) begin
               swap      = 1'b1;
               state_nxt = FILL_BUSY;
            end
         end
         FILL_BUSY: begin
            if (i_write_done && i_read_done) begin
               swap      = 1'b1;
               state_nxt = FILL_BUSY;
            end else if (i_write_done) begin
               state_nxt = HOLD;
            end else if (i_read_done) begin
               state_nxt = FILL;
            end
         end
         HOLD: begin
            if (i_read_done) begin
               swap      = 1'b1;
               state_nxt = FILL_BUSY;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state         <= FILL;
         wr_bank       <= 1'b0;
         o_swap        <= 1'b0;
         o_frame_count <= '0;
      end else begin
         state  <= state_nxt;
         o_swap <= swap;
         if (swap) begin
            wr_bank       <= ~wr_bank;
            o_frame_count <= o_frame_count + 1'b1;
         end
      end
   end

   // Port A is written last so it wins an address tie.
   always_ff @(posedge i_CLK) begin
      if (wr_ok_B)
         mem[{wr_bank, i_write_addr_B}] <= i_write_data_B;
      if (wr_ok_A)
         mem[{wr_bank, i_write_addr_A}] <= i_write_data_A;
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         o_collision    <= 1'b0;
         o_read_valid_A <= 1'b0;
         o_read_valid_B <= 1'b0;
         o_read_data_A  <= '0;
         o_read_data_B  <= '0;
      end else begin
         o_collision    <= wr_ok_A & wr_ok_B &
                           (i_write_addr_A == i_write_addr_B);
         o_read_valid_A <= rd_ok_A;
         o_read_valid_B <= rd_ok_B;
         if (rd_ok_A)
            o_read_data_A <= mem[{~wr_bank, i_read_addr_A}];
         if (rd_ok_B)
            o_read_data_B <= mem[{~wr_bank, i_read_addr_B}];
      end
   end

endmodule

// File: tb/tb_pingpong_ram2b.sv
// Directed bench for pingpong_ram2b: fill, swap, read, collision, reset, wrap.
module tb_pingpong_ram2b;

   localparam int W  = 16;
   localparam int AW = 5;
   localparam int CW = 8;

   logic          i_CLK, i_RST;
   logic          i_write_en_A, i_write_en_B;
   logic [AW-1:0] i_write_addr_A, i_write_addr_B;
   logic [W-1:0]  i_write_data_A, i_write_data_B;
   logic          i_write_done, o_write_ready;
   logic          i_read_en_A, i_read_en_B;
   logic [AW-1:0] i_read_addr_A, i_read_addr_B;
   logic          i_read_done, o_read_ready;
   logic [W-1:0]  o_read_data_A, o_read_data_B;
   logic          o_read_valid_A, o_read_valid_B;
   logic          o_swap, o_collision;
   logic [CW-1:0] o_frame_count;

   int checks = 0;
   int errors = 0;

   pingpong_ram2b dut (
      .i_CLK(i_CLK), .i_RST(i_RST),
      .i_write_en_A(i_write_en_A), .i_write_en_B(i_write_en_B),
      .i_write_addr_A(i_write_addr_A), .i_write_addr_B(i_write_addr_B),
      .i_write_data_A(i_write_data_A), .i_write_data_B(i_write_data_B),
      .i_write_done(i_write_done), .o_write_ready(o_write_ready),
      .i_read_en_A(i_read_en_A), .i_read_en_B(i_read_en_B),
      .i_read_addr_A(i_read_addr_A), .i_read_addr_B(i_read_addr_B),
      .i_read_done(i_read_done), .o_read_ready(o_read_ready),
      .o_read_data_A(o_read_data_A), .o_read_data_B(o_read_data_B),
      .o_read_valid_A(o_read_valid_A), .o_read_valid_B(o_read_valid_B),
      .o_swap(o_swap), .o_collision(o_collision),
      .o_frame_count(o_frame_count)
   );

   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic idle();
      i_write_en_A = 0; i_write_en_B = 0;
      i_read_en_A  = 0; i_read_en_B  = 0;
      i_write_done = 0; i_read_done  = 0;
   endtask

   task automatic wr2(input logic [AW-1:0] aa, input logic [W-1:0] da,
                      input logic [AW-1:0] ab, input logic [W-1:0] db);
      i_write_en_A = 1; i_write_addr_A = aa; i_write_data_A = da;
      i_write_en_B = 1; i_write_addr_B = ab; i_write_data_B = db;
      step();
      i_write_en_A = 0; i_write_en_B = 0;
   endtask

   task automatic fill(input logic [W-1:0] base);
      for (int i = 0; i < 16; i++)
         wr2(AW'(2*i), base + W'(2*i), AW'(2*i+1), base + W'(2*i+1));
   endtask

   task automatic rd2(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
      i_read_en_A = 1; i_read_addr_A = aa;
      i_read_en_B = 1; i_read_addr_B = ab;
      step();
      i_read_en_A = 0; i_read_en_B = 0;
   endtask

   initial begin
      i_RST = 1;
      i_write_addr_A = '0; i_write_addr_B = '0;
      i_write_data_A = '0; i_write_data_B = '0;
      i_read_addr_A  = '0; i_read_addr_B  = '0;
      idle();
      step(); step();
      chk("rst_wready", 32'(o_write_ready), 32'd1);
      chk("rst_rready", 32'(o_read_ready), 32'd0);
      chk("rst_dataA", 32'(o_read_data_A), 32'd0);
      chk("rst_dataB", 32'(o_read_data_B), 32'd0);
      chk("rst_validA", 32'(o_read_valid_A), 32'd0);
      chk("rst_swap", 32'(o_swap), 32'd0);
      chk("rst_coll", 32'(o_collision), 32'd0);
      chk("rst_fc", 32'(o_frame_count), 32'd0);
      i_RST = 0;
      step();

      // frame 1
      fill(16'h1000);
      chk("f1_no_swap", 32'(o_swap), 32'd0);
      i_write_done = 1; step(); i_write_done = 0;
      chk("f1_swap", 32'(o_swap), 32'd1);
      chk("f1_rready", 32'(o_read_ready), 32'd1);
      chk("f1_fc", 32'(o_frame_count), 32'd1);
      chk("f1_wready", 32'(o_write_ready), 32'd1);
      step();
      chk("f1_swap_pulse", 32'(o_swap), 32'd0);

      rd2(5'd5, 5'd26);
      chk("f1_rdA", 32'(o_read_data_A), 32'h1005);
      chk("f1_rdB", 32'(o_read_data_B), 32'h101A);
      chk("f1_vA", 32'(o_read_valid_A), 32'd1);
      chk("f1_vB", 32'(o_read_valid_B), 32'd1);
      step();
      chk("f1_vA_off", 32'(o_read_valid_A), 32'd0);
      chk("f1_rdA_hold", 32'(o_read_data_A), 32'h1005);

      // frame 2 with a collision on address 7
      fill(16'h2000);
      chk("f2_coll_idle", 32'(o_collision), 32'd0);
      wr2(5'd7, 16'hAAAA, 5'd7, 16'h5555);
      chk("f2_coll", 32'(o_collision), 32'd1);
      step();
      chk("f2_coll_pulse", 32'(o_collision), 32'd0);
      i_write_done = 1; step(); i_write_done = 0;
      chk("f2_hold_wready", 32'(o_write_ready), 32'd0);
      chk("f2_hold_swap", 32'(o_swap), 32'd0);
      chk("f2_hold_fc", 32'(o_frame_count), 32'd1);
      chk("f2_hold_rready", 32'(o_read_ready), 32'd1);
      wr2(5'd5, 16'hDEAD, 5'd6, 16'hBEEF);
      chk("f2_ign_coll", 32'(o_collision), 32'd0);
      i_read_done = 1; step(); i_read_done = 0;
      chk("f2_swap", 32'(o_swap), 32'd1);
      chk("f2_fc", 32'(o_frame_count), 32'd2);
      chk("f2_wready", 32'(o_write_ready), 32'd1);
      rd2(5'd5, 5'd7);
      chk("f2_rd5", 32'(o_read_data_A), 32'h2005);
      chk("f2_rd7", 32'(o_read_data_B), 32'hAAAA);
      rd2(5'd6, 5'd31);
      chk("f2_rd6", 32'(o_read_data_A), 32'h2006);
      chk("f2_rd31", 32'(o_read_data_B), 32'h201F);

      // frame 3: both dones together, plus a write on the swap edge
      wr2(5'd2, 16'h3002, 5'd3, 16'h3003);
      i_write_en_A = 1; i_write_addr_A = 5'd9; i_write_data_A = 16'h3009;
      i_read_en_A = 1; i_read_addr_A = 5'd9;
      i_write_done = 1; i_read_done = 1;
      step();
      idle();
      chk("f3_swap", 32'(o_swap), 32'd1);
      chk("f3_fc", 32'(o_frame_count), 32'd3);
      chk("f3_old_rd", 32'(o_read_data_A), 32'h2009);
      step();
      chk("f3_swap_once", 32'(o_swap), 32'd0);
      chk("f3_fc_once", 32'(o_frame_count), 32'd3);
      chk("f3_rready", 32'(o_read_ready), 32'd1);
      rd2(5'd2, 5'd9);
      chk("f3_rd2", 32'(o_read_data_A), 32'h3002);
      chk("f3_rd9", 32'(o_read_data_B), 32'h3009);

      // asynchronous reset in the middle of a read burst
      i_read_en_A = 1; i_read_addr_A = 5'd3;
      step();
      chk("mid_vA", 32'(o_read_valid_A), 32'd1);
      i_RST = 1;
      #1;
      chk("ar_dataA", 32'(o_read_data_A), 32'd0);
      chk("ar_vA", 32'(o_read_valid_A), 32'd0);
      chk("ar_rready", 32'(o_read_ready), 32'd0);
      chk("ar_wready", 32'(o_write_ready), 32'd1);
      chk("ar_fc", 32'(o_frame_count), 32'd0);
      idle();
      step();
      i_RST = 0;
      step();
      chk("ar_after_rready", 32'(o_read_ready), 32'd0);

      // 256 swaps wrap the frame counter
      i_write_done = 1; i_read_done = 1;
      for (int i = 0; i < 255; i++) step();
      chk("wrap_255", 32'(o_frame_count), 32'd255);
      step();
      idle();
      chk("wrap_0", 32'(o_frame_count), 32'd0);
      chk("wrap_swap", 32'(o_swap), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pingpong_ram2b.md
Name: pingpong_ram2b

Overview:
Double-buffered, two-write/two-read memory for the FFT signal-scramble stage. It holds two banks of MEM_SIZE words. The writer side fills one bank through two write ports while the reader side drains the other bank through two read ports. Banks swap on a done/done handshake, so one frame can be loaded while the previous frame is read out in scrambled (e.g. bit-reversed) order.

Parameters:
WORD_SIZE, 16, data word width
MEM_SIZE, 32, words per bank (frame length)
ADDR_SIZE, $clog2(MEM_SIZE), address width within a bank
CNT_SIZE, 8, width of frame counter

Ports:
i_CLK  in  1  clock, all state on rising edge
i_RST  in  1  asynchronous, active-high reset
i_write_en_A  in  1  write strobe, port A
i_write_en_B  in  1  write strobe, port B
i_write_addr_A  in  ADDR_SIZE  write address A (in write bank)
i_write_addr_B  in  ADDR_SIZE  write address B
i_write_data_A  in  WORD_SIZE  write data A
i_write_data_B  in  WORD_SIZE  write data B
i_write_done  in  1  pulse: write bank frame complete
o_write_ready  out  1  write bank accepts writes
i_read_en_A  in  1  read strobe, port A
i_read_en_B  in  1  read strobe, port B
i_read_addr_A  in  ADDR_SIZE  read address A (in read bank)
i_read_addr_B  in  ADDR_SIZE  read address B
i_read_done  in  1  pulse: read bank fully consumed
o_read_ready  out  1  read bank holds a valid frame
o_read_data_A  out  WORD_SIZE  registered read data A
o_read_data_B  out  WORD_SIZE  registered read data B
o_read_valid_A  out  1  o_read_data_A valid this cycle
o_read_valid_B  out  1  o_read_data_B valid this cycle
o_swap  out  1  one-cycle pulse on bank swap
o_collision  out  1  one-cycle pulse: A and B wrote same address
o_frame_count  out  CNT_SIZE  frames handed to reader, wraps

Behaviour:
- Storage is 2*MEM_SIZE words. wr_bank selects the write bank; the read bank is always ~wr_bank. Memory contents are not cleared by reset.
- Reset (async, i_RST=1) values: wr_bank=0, wr_done_flag=0, rd_full=0.
- Reset outputs: o_write_ready=1, o_read_ready=0, o_read_data_A/B=0, o_read_valid_A/B=0, o_swap=0, o_collision=0, o_frame_count=0.
- A reset mid-frame discards both frames.
- o_write_ready = ~wr_done_flag. o_read_ready = rd_full.
- Write: on a clock edge, a port with i_write_en_x=1 and o_write_ready=1 stores to [wr_bank][addr]. Writes while o_write_ready=0 are ignored.
- Write collision: both ports enabled with equal addresses -> port A data is stored, and o_collision pulses the next cycle.
- Read: i_read_en_x=1 with o_read_ready=1 -> o_read_data_x <= [~wr_bank][addr], o_read_valid_x=1 the next cycle (latency 1).
- Read with read disabled or not ready -> o_read_valid_x=0 and o_read_data_x holds its previous value.
- Reading an address being written this cycle is impossible (the banks differ).
- i_write_done while o_write_ready=1 sets wr_done_flag. i_read_done while rd_full=1 clears rd_full. Done pulses in the wrong state are ignored.
- Swap condition, evaluated each cycle on the effective values including same-cycle done pulses: write frame complete AND read side empty (~rd_full).
- On swap (registered): wr_bank toggles, wr_done_flag=0, rd_full=1, o_frame_count+1 (wraps to 0), o_swap=1 for one cycle.
- Same-cycle events:
  - i_write_done and i_read_done together with rd_full=1 -> swap that edge.
  - i_write_done with rd_full=0 -> swap that edge; wr_done_flag is never visibly set.
- Writes on the swap edge land in the old write bank. Reads on the swap edge use the old read bank.
- Control state is one of: FILL (ready, reader empty), FILL_BUSY (ready, reader full), HOLD (writer done, reader full). There is no state with the writer done and the reader empty, because that condition swaps immediately.

Test Plan:
- Reset, write addr 0..31 with data 16'h1000+addr via A (even) and B (odd), pulse i_write_done -> next cycle o_swap=1, o_read_ready=1, o_frame_count=1.
- Read addr 5 on A and addr 26 on B -> one cycle later o_read_data_A=16'h1005, o_read_data_B=16'h101A, both valid.
- Fill frame 2, pulse i_write_done with rd_full=1 -> o_write_ready=0, writes ignored, no swap. Then i_read_done -> swap; reading addr 5 returns the frame-2 value.
- A and B both write addr 7 with 16'hAAAA / 16'h5555 -> o_collision pulse; after swap, read addr 7 = 16'hAAAA.
- i_write_done and i_read_done in the same cycle while in FILL_BUSY -> single o_swap, o_frame_count increments by exactly 1.
- Assert i_RST mid-read -> all outputs return to their reset values immediately. 256 swaps -> o_frame_count wraps to 0.
